// File: rtl/rp_tick_sched_if.sv
// Partition-facing bus of the tick scheduler: step strobe, direction,
// counter readback and the reconfiguration handshake / isolation control.
interface rp_tick_sched_if;
  logic       rp_tick;
  logic       rp_dir;
  logic [3:0] rp_dout;
  logic       pr_req;
  logic       pr_done;
  logic       pr_decouple;

  // Scheduler side
  modport master (
    output rp_tick, rp_dir, pr_decouple,
    input  rp_dout, pr_req, pr_done
  );

  // Partition / reconfiguration-controller side
  modport slave (
    input  rp_tick, rp_dir, pr_decouple,
    output rp_dout, pr_req, pr_done
  );
endinterface

// File: rtl/rp_tick_sched.sv
// Tick scheduler for a reconfigurable counter partition. Issues a one-cycle
// step strobe every 'period' cycles while running, samples the partition
// counter one cycle after each step, and sequences partial reconfiguration:
// drain the outstanding sample, isolate the partition, wait for reload,
// hold isolation for SETTLE cycles, then resume.
module rp_tick_sched #(
  parameter int unsigned PERIOD_RST = 10000000,
  parameter int unsigned SETTLE     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        period_ld,
  input  logic [31:0] period_val,
  input  logic        din,
  output logic [3:0]  dout,
  output logic [2:0]  state,
  output logic [7:0]  pr_count,
  rp_tick_sched_if.master pbus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_DRAIN     = 3'd2,
    S_DECOUPLED = 3'd3,
    S_RECOVER   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] ticks_reg, ticks_next;
  logic [31:0] period_reg;
  logic        decouple_reg, decouple_next;
  logic [15:0] settle_reg, settle_next;
  logic [7:0]  pr_count_reg, pr_count_next;
  logic        din_reg;
  logic        sample_pending_reg;
  logic [3:0]  dout_reg;
  logic        tick;

  // FSM and counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ticks_reg    <= '0;
      decouple_reg <= 1'b0;
      settle_reg   <= '0;
      pr_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ticks_reg    <= ticks_next;
      decouple_reg <= decouple_next;
      settle_reg   <= settle_next;
      pr_count_reg <= pr_count_next;
    end
  end

  // Next-state logic; the step strobe is decoded from the current count
  always_comb begin
    state_next    = state_reg;
    ticks_next    = ticks_reg;
    decouple_next = decouple_reg;
    settle_next   = settle_reg;
    pr_count_next = pr_count_reg;
    tick          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ticks_next = '0;
        if (pbus.pr_req)
          state_next = S_DRAIN;
        else if (run)
          state_next = S_RUN;
      end
      S_RUN: begin
        // >= so that shrinking the period mid-count fires on the next cycle
        if (ticks_reg >= period_reg - 32'd1) begin
          tick       = 1'b1;
          ticks_next = '0;
        end else begin
          ticks_next = ticks_reg + 32'd1;
        end
        if (pbus.pr_req) begin
          state_next = S_DRAIN;
        end else if (!run) begin
          state_next = S_IDLE;
          ticks_next = '0;
        end
      end
      S_DRAIN: begin
        // Wait for the last partition sample before isolating it
        if (!sample_pending_reg) begin
          decouple_next = 1'b1;
          state_next    = S_DECOUPLED;
        end
      end
      S_DECOUPLED: begin
        if (pbus.pr_done) begin
          state_next  = S_RECOVER;
          settle_next = '0;
        end
      end
      S_RECOVER: begin
        if (settle_reg == 16'(SETTLE - 1)) begin
          decouple_next = 1'b0;
          ticks_next    = '0;
          if (pr_count_reg != 8'hFF)
            pr_count_next = pr_count_reg + 8'd1;
          state_next = run ? S_RUN : S_IDLE;
        end else begin
          settle_next = settle_reg + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Period register; values below 2 would make the terminal count degenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      period_reg <= 32'(PERIOD_RST);
    else if (period_ld)
      period_reg <= (period_val < 32'd2) ? 32'd2 : period_val;
  end

  // Direction register and one-cycle-delayed capture of the partition counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_reg            <= 1'b0;
      sample_pending_reg <= 1'b0;
      dout_reg           <= '0;
    end else begin
      din_reg            <= din;
      sample_pending_reg <= tick;
      if (sample_pending_reg)
        dout_reg <= pbus.rp_dout;
    end
  end

  assign pbus.rp_tick     = tick;
  assign pbus.rp_dir      = din_reg;
  assign pbus.pr_decouple = decouple_reg;
  assign dout             = dout_reg;
  assign state            = state_reg;
  assign pr_count         = pr_count_reg;

endmodule

// File: tb/tb_rp_tick_sched.sv
// Bench for rp_tick_sched: directed stimulus pushes expected step strobes and
// dout updates into queues; a negedge monitor pops and compares them.
module tb_rp_tick_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        period_ld = 1'b0;
  logic [31:0] period_val = '0;
  logic        din = 1'b0;
  logic [3:0]  dout;
  logic [2:0]  state;
  logic [7:0]  pr_count;

  rp_tick_sched_if bus ();

  rp_tick_sched #(.PERIOD_RST(10000000), .SETTLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .period_ld  (period_ld),
    .period_val (period_val),
    .din        (din),
    .dout       (dout),
    .state      (state),
    .pr_count   (pr_count),
    .pbus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Partition counter model
  logic [3:0] part_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      part_cnt <= '0;
    else if (bus.rp_tick)
      part_cnt <= bus.rp_dir ? part_cnt - 4'd1 : part_cnt + 4'd1;
  end
  assign bus.rp_dout = part_cnt;

  int checks = 0;
  int errors = 0;
  int exp_tick_cyc[$];
  int exp_tick_dir[$];
  int exp_dout_cyc[$];
  int exp_dout_val[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expect a step at cycle c with direction dir; dout shows dv two cycles later
  task automatic push_tick(input int c, input int dir, input int dv);
    exp_tick_cyc.push_back(c);
    exp_tick_dir.push_back(dir);
    exp_dout_cyc.push_back(c + 2);
    exp_dout_val.push_back(dv);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, output bit ok);
    int n;
    n = 0;
    while (int'(state) != s && n < 40) begin
      nxt;
      n++;
    end
    ok = (int'(state) == s);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_state cycle %0d got state %0d expected %0d", cyc, state, s);
    end
  endtask

  // Monitor: compare every step strobe and dout update against the queues
  logic [3:0] dout_prev = '0;
  int mon_c;
  int mon_v;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rp_tick) begin
        if (exp_tick_cyc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick cycle %0d got rp_tick 1 expected 0", cyc);
        end else begin
          mon_c = exp_tick_cyc.pop_front();
          mon_v = exp_tick_dir.pop_front();
          check("tick_cycle", cyc, mon_c);
          check("tick_dir", int'(bus.rp_dir), mon_v);
        end
      end
      if (dout !== dout_prev) begin
        if (exp_dout_cyc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dout cycle %0d got %0d expected %0d", cyc, dout, dout_prev);
        end else begin
          mon_c = exp_dout_cyc.pop_front();
          mon_v = exp_dout_val.pop_front();
          check("dout_cycle", cyc, mon_c);
          check("dout_val", int'(dout), mon_v);
        end
      end
    end
    dout_prev = dout;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  int base;
  int d;
  bit ok;

  initial begin
    bus.pr_req  = 1'b0;
    bus.pr_done = 1'b0;
    repeat (3) nxt;

    // Reset state
    check("rst_state", int'(state), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_pr_count", int'(pr_count), 0);
    check("rst_rp_tick", int'(bus.rp_tick), 0);
    check("rst_rp_dir", int'(bus.rp_dir), 0);
    check("rst_decouple", int'(bus.pr_decouple), 0);
    rst_n = 1'b1;
    nxt;
    check("idle_state", int'(state), 0);

    // Period 5, counting up: steps every 5 cycles, dout 1,2,3
    base = cyc;
    period_ld = 1'b1; period_val = 32'd5; run = 1'b1; din = 1'b0;
    push_tick(base + 5, 0, 1);
    push_tick(base + 10, 0, 2);
    push_tick(base + 15, 0, 3);
    nxt;
    period_ld = 1'b0;
    check("run_state", int'(state), 1);
    repeat (15) nxt;
    run = 1'b0;
    nxt;
    check("stop_idle", int'(state), 0);
    repeat (2) nxt;

    // Period 0 clamps to 2, counting down from 3
    base = cyc;
    period_ld = 1'b1; period_val = 32'd0; run = 1'b1; din = 1'b1;
    push_tick(base + 2, 1, 2);
    push_tick(base + 4, 1, 1);
    push_tick(base + 6, 1, 0);
    nxt;
    period_ld = 1'b0;
    repeat (5) nxt;
    run = 1'b0;
    nxt;
    din = 1'b0;
    repeat (2) nxt;

    // Period 8, shrink to 4 once ticks reaches 6
    base = cyc;
    period_ld = 1'b1; period_val = 32'd8; run = 1'b1; din = 1'b0;
    push_tick(base + 7, 0, 1);
    push_tick(base + 11, 0, 2);
    push_tick(base + 15, 0, 3);
    push_tick(base + 19, 0, 4);
    nxt;
    period_ld = 1'b0;
    repeat (5) nxt;
    period_ld = 1'b1; period_val = 32'd4;
    nxt;
    period_ld = 1'b0;
    check("shrink_tick_now", int'(bus.rp_tick), 1);
    repeat (12) nxt;

    // Reconfiguration requested in a tick cycle
    bus.pr_req = 1'b1;
    check("req_tick_cycle", int'(bus.rp_tick), 1);
    nxt;
    bus.pr_req = 1'b0;
    bus.pr_done = 1'b1;
    check("drain_state", int'(state), 2);
    nxt;
    bus.pr_done = 1'b0;
    check("drain_hold", int'(state), 2);
    check("drain_decouple", int'(bus.pr_decouple), 0);
    nxt;
    check("decoupled_state", int'(state), 3);
    check("decoupled_flag", int'(bus.pr_decouple), 1);
    nxt;
    period_ld = 1'b1; period_val = 32'd6;
    nxt;
    period_ld = 1'b0;
    check("decoupled_stays", int'(state), 3);
    repeat (2) nxt;
    d = cyc;
    bus.pr_done = 1'b1;
    push_tick(d + 10, 0, 5);
    nxt;
    bus.pr_done = 1'b0;
    check("recover_state", int'(state), 4);
    repeat (3) nxt;
    check("settle_decouple", int'(bus.pr_decouple), 1);
    check("settle_state", int'(state), 4);
    nxt;
    check("released_decouple", int'(bus.pr_decouple), 0);
    check("resume_run", int'(state), 1);
    check("pr_count_one", int'(pr_count), 1);

    // Stray pr_done while running
    nxt;
    bus.pr_done = 1'b1;
    nxt;
    bus.pr_done = 1'b0;
    check("stray_done_run", int'(state), 1);
    nxt;
    check("stray_done_run2", int'(state), 1);
    repeat (3) nxt;
    run = 1'b0;
    nxt;
    check("idle_before_loop", int'(state), 0);

    // Repeated reconfigurations with pr_req held high: pr_count saturates
    bus.pr_req = 1'b1;
    for (int i = 0; i < 259; i++) begin
      wait_state(3, ok);
      if (!ok) break;
      bus.pr_done = 1'b1;
      nxt;
      bus.pr_done = 1'b0;
    end
    wait_state(3, ok);
    check("pr_count_sat", int'(pr_count), 255);
    check("dout_held", int'(dout), 5);
    check("loop_decouple", int'(bus.pr_decouple), 1);

    // Asynchronous reset while decoupled
    #2;
    rst_n = 1'b0;
    bus.pr_req = 1'b0;
    #1;
    check("arst_decouple", int'(bus.pr_decouple), 0);
    check("arst_dout", int'(dout), 0);
    check("arst_state", int'(state), 0);
    check("arst_pr_count", int'(pr_count), 0);
    nxt;
    nxt;
    rst_n = 1'b1;
    nxt;
    check("post_rst_idle", int'(state), 0);
    nxt;
    check("post_rst_idle2", int'(state), 0);
    repeat (3) nxt;

    while (exp_tick_cyc.size() > 0) begin
      mon_c = exp_tick_cyc.pop_front();
      void'(exp_tick_dir.pop_front());
      checks++;
      errors++;
      $display("FAIL missing_tick got none expected tick at cycle %0d", mon_c);
    end
    while (exp_dout_cyc.size() > 0) begin
      mon_c = exp_dout_cyc.pop_front();
      mon_v = exp_dout_val.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_dout got none expected %0d at cycle %0d", mon_v, mon_c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
